// File: rtl/aurora_to_fifo.sv
// Aurora user-RX AXI4-Stream reassembler: gathers the beats of one frame into a
// PACKET_SIZE_BITS word (first beat in the MSBs) and writes it to the RX packet FIFO.
module aurora_to_fifo #(
  parameter int         PACKET_SIZE_BITS = 1024,
  parameter int         NUMBER_OF_LANES  = 2,
  parameter logic [7:0] ID_LOCAL_FPGA    = 8'h00
) (
  input  logic                          user_clk,
  input  logic                          reset_TX_RX_Block,
  input  logic                          channel_up,
  input  logic [32*NUMBER_OF_LANES-1:0] m_axi_rx_tdata,
  input  logic                          m_axi_rx_tvalid,
  input  logic                          m_axi_rx_tlast,
  input  logic                          full,
  output logic                          wr_en,
  output logic [PACKET_SIZE_BITS-1:0]   din,
  output logic [15:0]                   pkt_drop_cnt,
  output logic [15:0]                   pkt_err_cnt
);

  localparam int N      = 32 * NUMBER_OF_LANES;
  localparam int P      = PACKET_SIZE_BITS;
  localparam int BPB    = N / 8;
  localparam int NB     = P / N;
  localparam int CW     = $clog2(NB + 1);
  localparam int BPB_SH = $clog2(BPB);
  localparam int MAXB   = P / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t        state_q;
  logic [P-1:0]  asm_q;
  logic [P-1:0]  din_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] eb_q;
  logic          id_ok_q;
  logic          wr_en_q;
  logic [15:0]   drop_q;
  logic [15:0]   err_q;

  logic [7:0]    hdr_dst;
  logic [15:0]   hdr_len;
  logic [17:0]   hdr_bytes;
  logic [17:0]   hdr_beats;
  logic          hdr_legal;
  logic          hdr_id_ok;
  logic [CW-1:0] hdr_eb_d;
  logic [CW-1:0] cnt_inc_d;
  logic          beat_ok;
  logic [P-1:0]  asm_hdr_d;
  logic [P-1:0]  asm_next_d;
  logic [P-1:0]  commit_word_d;
  logic          commit_id_ok_d;
  logic          commit_d;
  logic          err_d;
  logic          drop_d;
  logic          write_d;

  // Header decode: word0[23:16] is the destination ID, word1[15:0] the payload length.
  always_comb begin
    hdr_dst   = m_axi_rx_tdata[N-9 -: 8];
    hdr_len   = m_axi_rx_tdata[N-49 -: 16];
    hdr_bytes = {2'b00, hdr_len} + 18'd8;
    hdr_legal = (hdr_bytes <= 18'(MAXB));
    hdr_beats = (hdr_bytes + 18'(BPB - 1)) >> BPB_SH;
    hdr_eb_d  = CW'(hdr_beats);
    hdr_id_ok = (hdr_dst == ID_LOCAL_FPGA);
    beat_ok   = channel_up && m_axi_rx_tvalid;
    cnt_inc_d = cnt_q + CW'(1);
  end

  always_comb begin
    asm_hdr_d = '0;
    asm_hdr_d[P-1 -: N] = m_axi_rx_tdata;
    asm_next_d = asm_q;
    for (int k = 0; k < NB; k++) begin
      if (cnt_q == CW'(k)) asm_next_d[P-1-k*N -: N] = m_axi_rx_tdata;
    end
  end

  // Frame events for the current cycle; a commit always carries the tlast beat's data.
  always_comb begin
    commit_d       = 1'b0;
    err_d          = 1'b0;
    commit_id_ok_d = (state_q == IDLE) ? hdr_id_ok : id_ok_q;
    commit_word_d  = (state_q == IDLE) ? asm_hdr_d : asm_next_d;
    case (state_q)
      IDLE: begin
        if (beat_ok) begin
          if (!hdr_legal)          err_d    = 1'b1;
          else if (m_axi_rx_tlast) commit_d = 1'b1;
        end
      end
      ASSEMBLE: begin
        if (!channel_up) begin
          err_d = 1'b1;
        end else if (m_axi_rx_tvalid) begin
          if (m_axi_rx_tlast) begin
            if (cnt_inc_d == eb_q) commit_d = 1'b1;
            else                   err_d    = 1'b1;
          end else if (cnt_inc_d == CW'(NB)) begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    drop_d  = commit_d && (!commit_id_ok_d || full);
    write_d = commit_d && commit_id_ok_d && !full;
  end

  always_ff @(posedge user_clk or posedge reset_TX_RX_Block) begin
    if (reset_TX_RX_Block) begin
      state_q <= IDLE;
      asm_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      eb_q    <= '0;
      id_ok_q <= 1'b0;
      wr_en_q <= 1'b0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      wr_en_q <= write_d;
      if (write_d) din_q <= commit_word_d;
      if (drop_d && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (err_d && (err_q != 16'hFFFF))   err_q  <= err_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (beat_ok) begin
            asm_q   <= asm_hdr_d;
            cnt_q   <= CW'(1);
            eb_q    <= hdr_eb_d;
            id_ok_q <= hdr_id_ok;
            if (!hdr_legal)           state_q <= m_axi_rx_tlast ? IDLE : DISCARD;
            else if (!m_axi_rx_tlast) state_q <= ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (!channel_up) begin
            state_q <= IDLE;
          end else if (m_axi_rx_tvalid) begin
            asm_q <= asm_next_d;
            cnt_q <= cnt_inc_d;
            if (m_axi_rx_tlast)               state_q <= IDLE;
            else if (cnt_inc_d == CW'(NB))    state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (!channel_up || (m_axi_rx_tvalid && m_axi_rx_tlast)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en        = wr_en_q;
  assign din          = din_q;
  assign pkt_drop_cnt = drop_q;
  assign pkt_err_cnt  = err_q;

endmodule

// File: doc/aurora_to_fifo.md
# aurora_to_fifo

Receive-side counterpart of the FIFO-to-Aurora transmit block. It accepts Aurora user-RX AXI4-Stream beats of 32·NUMBER_OF_LANES bits and reassembles each frame into one PACKET_SIZE_BITS word, first beat in the MSBs. It validates the header, then writes the word into the RX packet FIFO with one `wr_en` pulse. Aurora RX has no backpressure, so frames that cannot be stored are dropped and counted.

## Interface
- PACKET_SIZE_BITS, 1024: packet width. Must be a multiple of n.
- NUMBER_OF_LANES, 2: Aurora lanes. Legal values are 2 and 4. Beat width is n = 32·NUMBER_OF_LANES (local), and BPB = n/8 bytes per beat.
- ID_LOCAL_FPGA, 8'h00: this FPGA's ID.
- user_clk, input, 1: single clock, Aurora user clock.
- reset_TX_RX_Block, input, 1: asynchronous, active-high reset.
- channel_up, input, 1: Aurora channel status.
- m_axi_rx_tdata, input, n: RX beat data.
- m_axi_rx_tvalid, input, 1: beat valid.
- m_axi_rx_tlast, input, 1: last beat of frame.
- full, input, 1: packet FIFO full.
- wr_en, output, 1: one-cycle FIFO write strobe.
- din, output, PACKET_SIZE_BITS: packet word presented to the FIFO.
- pkt_drop_cnt, output, 16: saturating count of frames dropped for ID mismatch or FIFO full.
- pkt_err_cnt, output, 16: saturating count of frames with length, overflow or channel errors.

## Operation
- Header is in the first beat, tdata[n-1:n-64]:
  - word0 = tdata[n-1:n-32]; word0[23:16] is the destination FPGA ID.
  - word1 = tdata[n-33:n-64]; word1[15:0] is LEN, the payload bytes following the 8-byte header.
- Expected beats: EB = ceil((8+LEN)/BPB).
  - Legal when 8+LEN ≤ PACKET_SIZE_BITS/8.
  - Example: 1024 bits, 2 lanes, LEN=0x78 gives EB=16.
- FSM states: IDLE, ASSEMBLE, DISCARD.
- IDLE, on a valid beat:
  - Load the beat into assembly bits [P-1:P-n], where P = PACKET_SIZE_BITS, and clear all lower bits.
  - Set beat counter to 1 and latch EB and the ID-match result.
  - If LEN is illegal: count an error; go to IDLE if tlast, otherwise DISCARD.
  - Otherwise, if tlast: commit (see below). Otherwise go to ASSEMBLE.
- ASSEMBLE, on a valid beat:
  - Store beat k at bits [P-1-k·n : P-(k+1)·n], then increment the counter.
  - If the counter reaches P/n without tlast: overflow. Count an error and go to DISCARD.
  - On tlast: if beat count ≠ EB, count an error and go to IDLE; otherwise commit.
- DISCARD: ignore beats until a valid tlast, then go to IDLE.
- Commit is performed on the tlast beat; the FSM returns to IDLE.
  - ID mismatch: increment pkt_drop_cnt, no write.
  - ID match with full=1 sampled on the tlast cycle: increment pkt_drop_cnt, no write.
  - Otherwise: copy the assembly register to the din register and assert wr_en on the next cycle.
- Unreceived low bits of din are zero. Both counters hold at 16'hFFFF.
- channel_up=0 in ASSEMBLE or DISCARD: abort the frame, count an error if in ASSEMBLE, and go to IDLE. Beats are ignored while channel_up=0.

## Timing
- Reset values: wr_en=0, din=0, both counters 0, FSM in IDLE, assembly register 0.
- Latency: wr_en=1 for exactly one cycle, the cycle after the accepted tlast beat. din is stable from that cycle until the next commit.
- The assembly register is separate from the din register. A new header beat on the cycle immediately after tlast is accepted while wr_en is high; back-to-back frames require no gap.
- tvalid=0 cycles inside a frame are idle and do not advance the counter.
- Counter increments take effect one cycle after the causing beat.
- Reset mid-frame discards the partial frame immediately. The first valid beat after reset deassertion is treated as a header.

## Test plan
- **Full frame.** 1024-bit, 2-lane; header 0x00000000_01000078 followed by 15 beats, tlast on beat 16.
  - Required: one wr_en pulse the cycle after beat 16.
  - Required: din equals the concatenated beats.
- **Short frame.** LEN=0x08, 2 beats, tlast on beat 2.
  - Required: din[1023:896] holds the two beats and the remainder is zero; wr_en pulses once.
- **Back-to-back with gaps.** Three LEN=0x78 frames with no idle between frames and random tvalid gaps inside frames.
  - Required: three writes, correct data, counters stay 0.
- **Drops.** One frame with word0=0x00010001 (ID 1) while ID_LOCAL_FPGA=0, and one matching frame with full=1 at tlast.
  - Required: no wr_en; pkt_drop_cnt=2.
- **Length errors.** One frame with LEN=0x78 and tlast on beat 10, one with 18 beats without tlast, and one with LEN=0x80.
  - Required: no writes; pkt_err_cnt=3; the following good frame is written correctly.
- **Abort.** channel_up drops at beat 5, then reset_TX_RX_Block is asserted mid-frame.
  - Required: no writes; pkt_err_cnt=1, then 0 after reset.
  - Required: the next clean frame is written.
